// File: rtl/spi_shifter_pkg.sv
// Shared types and defaults for the SPI serial/parallel shift engine.
// Build option SPI_SHIFTER_LSB_FIRST_EN (see spi_shifter) enables LSB-first ordering.
package spi_shifter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/spi_shifter_if.sv
// Handshake and data bundle between the shift engine, the SCLK edge detector
// and the command logic; clock and reset stay outside as plain ports.
interface spi_shifter_if #(
  parameter int WIDTH = spi_shifter_pkg::DEFAULT_WIDTH
);
  import spi_shifter_pkg::*;

  localparam int CNTW = $clog2(WIDTH + 1);

  logic             start;
  logic             lsbFirst;
  logic [WIDTH-1:0] parallelDataIn;
  logic             sampleEdge;
  logic             shiftEdge;
  logic             serialDataIn;
  logic             serialDataOut;
  logic [WIDTH-1:0] parallelDataOut;
  logic             busy;
  logic             done;
  logic [CNTW-1:0]  bitCount;

  modport master (
    output start, lsbFirst, parallelDataIn, sampleEdge, shiftEdge, serialDataIn,
    input  serialDataOut, parallelDataOut, busy, done, bitCount
  );

  modport slave (
    input  start, lsbFirst, parallelDataIn, sampleEdge, shiftEdge, serialDataIn,
    output serialDataOut, parallelDataOut, busy, done, bitCount
  );

endinterface

// File: rtl/spi_shifter.sv
// SPI shift engine: transfer FSM, saturating bit counter and shift datapath.
// Define SPI_SHIFTER_LSB_FIRST_EN to honour lsbFirst; otherwise always MSB-first.
//
// state  | meaning
// IDLE   | waiting for start, strobes ignored
// ACTIVE | sampling/shifting bits of the current word
// DONE   | one-cycle completion, start accepted here too
module spi_shifter
  import spi_shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic        clk,
  input logic        resetN,
  spi_shifter_if.slave bus
);

  localparam int CNTW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             in_bit;
  logic             pending;
  logic [CNTW-1:0]  bit_count;
  logic             busy_q;
  logic             done_q;

  logic             shift_fire;
  logic             shift_bit;
  logic             last_shift;
  logic [WIDTH-1:0] shreg_next;
  logic [CNTW-1:0]  count_inc;

`ifdef SPI_SHIFTER_LSB_FIRST_EN
  logic lsb_q;
`else
  logic unused_lsb_first;
  assign unused_lsb_first = bus.lsbFirst;
`endif

  // A held sample is always shifted before a same-cycle fresh one, so
  // bits enter the register in the order they were sampled.
  always_comb begin
    shift_fire = bus.shiftEdge && (pending || bus.sampleEdge);
    shift_bit  = pending ? in_bit : bus.serialDataIn;
    last_shift = shift_fire && ((bit_count - CNTW'(pending)) == CNTW'(WIDTH - 1));
    count_inc  = (bit_count == CNTW'(WIDTH)) ? bit_count : bit_count + 1'b1;
`ifdef SPI_SHIFTER_LSB_FIRST_EN
    shreg_next = lsb_q ? {shift_bit, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], shift_bit};
`else
    shreg_next = {shreg[WIDTH-2:0], shift_bit};
`endif
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      shreg     <= '0;
      in_bit    <= 1'b0;
      pending   <= 1'b0;
      bit_count <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SPI_SHIFTER_LSB_FIRST_EN
      lsb_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            shreg     <= bus.parallelDataIn;
            bit_count <= '0;
            pending   <= 1'b0;
            busy_q    <= 1'b1;
            state     <= ACTIVE;
`ifdef SPI_SHIFTER_LSB_FIRST_EN
            lsb_q     <= bus.lsbFirst;
`endif
          end else begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        ACTIVE: begin
          if (bus.sampleEdge) bit_count <= count_inc;
          if (shift_fire) shreg <= shreg_next;
          if (bus.sampleEdge && (pending || !bus.shiftEdge)) begin
            in_bit  <= bus.serialDataIn;
            pending <= 1'b1;
          end else if (shift_fire) begin
            pending <= 1'b0;
          end
          if (last_shift) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_SHIFTER_LSB_FIRST_EN
  assign bus.serialDataOut = lsb_q ? shreg[0] : shreg[WIDTH-1];
`else
  assign bus.serialDataOut = shreg[WIDTH-1];
`endif
  assign bus.parallelDataOut = shreg;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.bitCount        = bit_count;

endmodule

// File: tb/tb_spi_shifter.sv
// Self-checking bench for spi_shifter (WIDTH=8) against a word-level model:
// expected register contents are computed from the load and receive words.
module tb_spi_shifter;
  import spi_shifter_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  spi_shifter_if #(.WIDTH(WIDTH)) bus ();

  spi_shifter #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Register contents after j shifts of a transfer that loaded 'load' and
  // receives the word 'rx' in the chosen order.
  function automatic logic [7:0] model_shreg(input logic [7:0] load, input logic [7:0] rx,
                                             input logic eff, input int j);
    int w;
    if (j == 0) return load;
    if (!eff) w = (int'(load) << j) | (int'(rx) >> (8 - j));
    else      w = (int'(load) >> j) | ((int'(rx) & ((1 << j) - 1)) << (8 - j));
    return w[7:0];
  endfunction

  task automatic do_transfer(input logic [7:0] load, input logic [7:0] rx, input logic lsb,
                             input bit both, input int mid_start, input int extra_shift,
                             input int abort_at, input bit skip_start, input bit chain,
                             input logic [7:0] chain_load);
    logic       eff;
    logic       b;
    logic       exp_tx;
    logic [7:0] exp_sh;
`ifdef SPI_SHIFTER_LSB_FIRST_EN
    eff = lsb;
`else
    eff = 1'b0;
`endif
    if (!skip_start) begin
      bus.start = 1'b1; bus.parallelDataIn = load; bus.lsbFirst = lsb;
      @(negedge clk);
      bus.start = 1'b0; bus.parallelDataIn = 8'($urandom);
    end
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.bitCount !== 4'd0 || bus.parallelDataOut !== load) begin
      n_err++;
      $display("FAIL start_accept: busy=%b done=%b cnt=%0d pdo=%h, expected busy=1 done=0 cnt=0 pdo=%h",
               bus.busy, bus.done, bus.bitCount, bus.parallelDataOut, load);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == abort_at) begin
        #2 resetN = 1'b0;
        #1;
        n_cmp++;
        if ({bus.serialDataOut, bus.parallelDataOut, bus.busy, bus.done, bus.bitCount} !== '0) begin
          n_err++;
          $display("FAIL async_reset: sdo=%b pdo=%h busy=%b done=%b cnt=%0d, expected all 0",
                   bus.serialDataOut, bus.parallelDataOut, bus.busy, bus.done, bus.bitCount);
        end
        @(negedge clk);
        resetN = 1'b1;
        return;
      end
      if (k == mid_start) begin
        bus.start = 1'b1; bus.parallelDataIn = 8'hFF; bus.lsbFirst = ~lsb;
        @(negedge clk);
        bus.start = 1'b0;
        exp_sh = model_shreg(load, rx, eff, k);
        n_cmp++;
        if (bus.parallelDataOut !== exp_sh || bus.bitCount !== 4'(k) || bus.busy !== 1'b1) begin
          n_err++;
          $display("FAIL start_ignored: pdo=%h cnt=%0d busy=%b, expected pdo=%h cnt=%0d busy=1",
                   bus.parallelDataOut, bus.bitCount, bus.busy, exp_sh, k);
        end
      end
      exp_tx = eff ? load[k] : load[7-k];
      n_cmp++;
      if (bus.serialDataOut !== exp_tx) begin
        n_err++;
        $display("FAIL tx_bit%0d: sdo=%b expected %b", k, bus.serialDataOut, exp_tx);
      end
      b = eff ? rx[k] : rx[7-k];
      if (both) begin
        bus.sampleEdge = 1'b1; bus.shiftEdge = 1'b1; bus.serialDataIn = b;
        @(negedge clk);
        bus.sampleEdge = 1'b0; bus.shiftEdge = 1'b0; bus.serialDataIn = 1'($urandom);
      end else begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.sampleEdge = 1'b1; bus.serialDataIn = b;
        @(negedge clk);
        bus.sampleEdge = 1'b0; bus.serialDataIn = 1'($urandom);
        exp_sh = model_shreg(load, rx, eff, k);
        n_cmp++;
        if (bus.bitCount !== 4'(k + 1) || bus.parallelDataOut !== exp_sh) begin
          n_err++;
          $display("FAIL sample%0d: cnt=%0d pdo=%h, expected cnt=%0d pdo=%h",
                   k, bus.bitCount, bus.parallelDataOut, k + 1, exp_sh);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.shiftEdge = 1'b1;
        @(negedge clk);
        bus.shiftEdge = 1'b0;
      end
      exp_sh = model_shreg(load, rx, eff, k + 1);
      n_cmp++;
      if (bus.bitCount !== 4'(k + 1) || bus.parallelDataOut !== exp_sh) begin
        n_err++;
        $display("FAIL shift%0d: cnt=%0d pdo=%h, expected cnt=%0d pdo=%h",
                 k, bus.bitCount, bus.parallelDataOut, k + 1, exp_sh);
      end
      if (k < 7) begin
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          n_err++;
          $display("FAIL mid_flags%0d: busy=%b done=%b, expected busy=1 done=0", k, bus.busy, bus.done);
        end
      end
      if (k == extra_shift && k < 7) begin
        bus.shiftEdge = 1'b1;
        @(negedge clk);
        bus.shiftEdge = 1'b0;
        n_cmp++;
        if (bus.parallelDataOut !== exp_sh || bus.bitCount !== 4'(k + 1) || bus.busy !== 1'b1) begin
          n_err++;
          $display("FAIL extra_shift: pdo=%h cnt=%0d busy=%b, expected pdo=%h cnt=%0d busy=1",
                   bus.parallelDataOut, bus.bitCount, bus.busy, exp_sh, k + 1);
        end
      end
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.parallelDataOut !== rx || bus.bitCount !== 4'd8) begin
      n_err++;
      $display("FAIL done_cycle: done=%b busy=%b pdo=%h cnt=%0d, expected done=1 busy=0 pdo=%h cnt=8",
               bus.done, bus.busy, bus.parallelDataOut, bus.bitCount, rx);
    end
    if (chain) begin
      bus.start = 1'b1; bus.parallelDataIn = chain_load; bus.lsbFirst = lsb;
      @(negedge clk);
      bus.start = 1'b0;
      return;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.parallelDataOut !== rx) begin
      n_err++;
      $display("FAIL after_done: done=%b busy=%b pdo=%h, expected done=0 busy=0 pdo=%h",
               bus.done, bus.busy, bus.parallelDataOut, rx);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.serialDataOut, bus.parallelDataOut, bus.busy, bus.done, bus.bitCount} !== '0) begin
      n_err++;
      $display("FAIL reset_state: sdo=%b pdo=%h busy=%b done=%b cnt=%0d, expected all 0",
               bus.serialDataOut, bus.parallelDataOut, bus.busy, bus.done, bus.bitCount);
    end
    resetN = 1'b1;
    @(negedge clk);
    bus.sampleEdge = 1'b1; bus.shiftEdge = 1'b1; bus.serialDataIn = 1'b1;
    repeat (3) @(negedge clk);
    bus.sampleEdge = 1'b0; bus.shiftEdge = 1'b0;
    n_cmp++;
    if (bus.parallelDataOut !== 8'h00 || bus.bitCount !== 4'd0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_strobes: pdo=%h cnt=%0d busy=%b, expected pdo=00 cnt=0 busy=0",
               bus.parallelDataOut, bus.bitCount, bus.busy);
    end
  endtask

  task automatic test_msb_first();
    do_transfer(8'b10001010, 8'h3C, 1'b0, 1'b0, -1, -1, -1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_lsb_first();
    do_transfer(8'b10001010, 8'h3C, 1'b1, 1'b0, -1, -1, -1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_both_strobes();
    do_transfer(8'h00, 8'hFF, 1'b0, 1'b1, -1, -1, -1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_start_ignored();
    do_transfer(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 3, -1, -1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_extra_shift();
    do_transfer(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, -1, 2, -1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid();
    do_transfer(8'hA5, 8'h5A, 1'b1, 1'b0, -1, -1, 3, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    n_cmp++;
    if (bus.parallelDataOut !== 8'h00 || bus.busy !== 1'b0 || bus.bitCount !== 4'd0) begin
      n_err++;
      $display("FAIL post_reset: pdo=%h busy=%b cnt=%0d, expected pdo=00 busy=0 cnt=0",
               bus.parallelDataOut, bus.busy, bus.bitCount);
    end
    do_transfer(8'($urandom), 8'($urandom), 1'b0, 1'b0, -1, -1, -1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ld_b;
    logic       lsb;
    ld_b = 8'($urandom);
    lsb  = 1'($urandom);
    do_transfer(8'($urandom), 8'($urandom), lsb, 1'b1, -1, -1, -1, 1'b0, 1'b1, ld_b);
    do_transfer(ld_b, 8'($urandom), lsb, 1'($urandom), -1, -1, -1, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      do_transfer(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  -1, -1, -1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    bus.start = 1'b0; bus.lsbFirst = 1'b0; bus.parallelDataIn = '0;
    bus.sampleEdge = 1'b0; bus.shiftEdge = 1'b0; bus.serialDataIn = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_both_strobes();
    test_start_ignored();
    test_extra_shift();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
